// File: rtl/tx_pkg.sv
// Shared types and default widths for the tx_arb transmit arbiter.
package tx_pkg;
  localparam int FLIT_W        = 8;
  localparam int BUFF_BITS_DEF = 3;
  localparam int PKT_FLITS_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SENDING,
    WAIT_REQ_DOWN
  } tx_state_e;

  // Select index width, never below one bit so N=1 still has a legal port.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/tx_arb_if.sv
// Channel, switch-request and buffer-read signals of one tx_arb port.
interface tx_arb_if
  import tx_pkg::*;
#(
  parameter int N         = 4,
  parameter int SIZE      = FLIT_W,
  parameter int BUFF_BITS = BUFF_BITS_DEF
);
  localparam int SELW = sel_w(N);

  logic                 ch_req;
  logic [SIZE-1:0]      ch_flit;
  logic                 ch_ack;
  logic [N-1:0]         sw_req;
  logic [N-1:0]         sw_gnt;
  logic [SELW-1:0]      buf_sel;
  logic [BUFF_BITS-1:0] buf_addr;
  logic [SIZE-1:0]      buf_data;
  logic                 busy;
  logic                 pkt_done;

  modport master (
    output ch_req, ch_flit, sw_gnt, buf_sel, buf_addr, busy, pkt_done,
    input  ch_ack, sw_req, buf_data
  );

  modport slave (
    input  ch_req, ch_flit, sw_gnt, buf_sel, buf_addr, busy, pkt_done,
    output ch_ack, sw_req, buf_data
  );
endinterface

// File: rtl/rr_arbiter.sv
// Source arbiter: round-robin from a held pointer when TX_ARB_RR_EN is
// defined, otherwise fixed priority with the lowest index winning.
module rr_arbiter
  import tx_pkg::*;
#(
  parameter  int N    = 4,
  localparam int SELW = sel_w(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req_i,
  input  logic [SELW-1:0] ptr_i,
  input  logic            upd_i,
  output logic [N-1:0]    gnt_o,
  output logic [SELW-1:0] idx_o
);
  logic [SELW-1:0] ptr_q;
  logic            found;

`ifdef TX_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (reset)      ptr_q <= '0;
    else if (upd_i) ptr_q <= ptr_i;
  end
`else
  logic unused_ptr;
  assign ptr_q      = '0;
  assign unused_ptr = ^{clk, reset, ptr_i, upd_i};
`endif

  function automatic logic [SELW-1:0] slot(input logic [SELW-1:0] p, input int i);
    return SELW'((int'(p) + i) % N);
  endfunction

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req_i[slot(ptr_q, i)]) begin
        found                 = 1'b1;
        idx_o                 = slot(ptr_q, i);
        gnt_o[slot(ptr_q, i)] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/tx_arb.sv
// Packet transmit arbiter: grants one source, streams PKT_FLITS flits over a
// two-phase req/ack channel. Build macro TX_ARB_RR_EN selects round-robin.
module tx_arb
  import tx_pkg::*;
#(
  parameter int ID        = 0,
  parameter int SUBID     = 0,
  parameter int N         = 4,
  parameter int SIZE      = FLIT_W,
  parameter int BUFF_BITS = BUFF_BITS_DEF,
  parameter int PKT_FLITS = PKT_FLITS_DEF
) (
  input logic      clk,
  input logic      reset,
  tx_arb_if.master bus
);
  localparam int SELW = sel_w(N);
  localparam int CW   = BUFF_BITS + 1;
  localparam logic [CW-1:0] LAST = CW'(PKT_FLITS);

  tx_state_e            state_q, state_d;
  logic                 ch_req_q, ch_req_d;
  logic [SIZE-1:0]      ch_flit_q, ch_flit_d;
  logic [N-1:0]         sw_gnt_q, sw_gnt_d;
  logic [SELW-1:0]      buf_sel_q, buf_sel_d;
  logic [BUFF_BITS-1:0] buf_addr_q, buf_addr_d;
  logic [CW-1:0]        sent_q, sent_d;
  logic                 pkt_done_q, pkt_done_d;
  logic                 ch_ack_old_q;
  logic                 ack, upd;
  logic [N-1:0]         arb_gnt;
  logic [SELW-1:0]      arb_idx, nxt_ptr;
  logic                 unused_ids;

  assign unused_ids = ^{ID[0], SUBID[0]};
  assign ack        = bus.ch_ack ^ ch_ack_old_q;
  assign nxt_ptr    = (buf_sel_q == SELW'(N - 1)) ? '0 : buf_sel_q + 1'b1;

  rr_arbiter #(.N(N)) u_arb (
    .clk   (clk),
    .reset (reset),
    .req_i (bus.sw_req),
    .ptr_i (nxt_ptr),
    .upd_i (upd),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      ch_req_q     <= 1'b0;
      ch_flit_q    <= '0;
      sw_gnt_q     <= '0;
      buf_sel_q    <= '0;
      buf_addr_q   <= '0;
      sent_q       <= '0;
      pkt_done_q   <= 1'b0;
      ch_ack_old_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ch_req_q     <= ch_req_d;
      ch_flit_q    <= ch_flit_d;
      sw_gnt_q     <= sw_gnt_d;
      buf_sel_q    <= buf_sel_d;
      buf_addr_q   <= buf_addr_d;
      sent_q       <= sent_d;
      pkt_done_q   <= pkt_done_d;
      ch_ack_old_q <= bus.ch_ack;
    end
  end

  // Acks outside SENDING fall through untouched, so they are never counted.
  always_comb begin
    state_d    = state_q;
    ch_req_d   = ch_req_q;
    ch_flit_d  = ch_flit_q;
    sw_gnt_d   = sw_gnt_q;
    buf_sel_d  = buf_sel_q;
    buf_addr_d = buf_addr_q;
    sent_d     = sent_q;
    pkt_done_d = 1'b0;
    upd        = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.sw_req) begin
          sw_gnt_d   = arb_gnt;
          buf_sel_d  = arb_idx;
          buf_addr_d = '0;
          state_d    = FETCH;
        end
      end
      FETCH: begin
        ch_flit_d  = bus.buf_data;
        ch_req_d   = ~ch_req_q;
        buf_addr_d = BUFF_BITS'(1);
        sent_d     = CW'(1);
        state_d    = SENDING;
      end
      SENDING: begin
        if (ack) begin
          if (sent_q == LAST) begin
            sw_gnt_d   = '0;
            pkt_done_d = 1'b1;
            state_d    = WAIT_REQ_DOWN;
          end else begin
            ch_flit_d  = bus.buf_data;
            ch_req_d   = ~ch_req_q;
            buf_addr_d = buf_addr_q + 1'b1;
            sent_d     = sent_q + 1'b1;
          end
        end
      end
      WAIT_REQ_DOWN: begin
        if (!bus.sw_req[buf_sel_q]) begin
          upd     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ch_req   = ch_req_q;
  assign bus.ch_flit  = ch_flit_q;
  assign bus.sw_gnt   = sw_gnt_q;
  assign bus.buf_sel  = buf_sel_q;
  assign bus.buf_addr = buf_addr_q;
  assign bus.pkt_done = pkt_done_q;
  assign bus.busy     = (state_q != IDLE);
endmodule

// File: tb/tb_tx_arb.sv
// Bench: three tx_arb instances (PKT_FLITS 4, 2, 8) against a packet-level model.
module tb_tx_arb;
  localparam int N  = 4;
  localparam int SZ = 8;
  localparam int BB = 3;
  localparam int ND = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [N-1:0]  sw_req [ND];
  logic          ch_ack [ND];
  logic [SZ-1:0] mem    [ND][N][1<<BB];

  logic          ch_req_w [ND];
  logic [SZ-1:0] flit_w   [ND];
  logic [N-1:0]  gnt_w    [ND];
  logic [1:0]    bsel_w   [ND];
  logic [BB-1:0] addr_w   [ND];
  logic          busy_w   [ND];
  logic          done_w   [ND];

  int   total = 0;
  int   bad   = 0;
  int   ptr_m    [ND];
  logic last_req [ND];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    localparam int PF = (g == 0) ? 4 : (g == 1) ? 2 : 8;
    tx_arb_if #(.N(N), .SIZE(SZ), .BUFF_BITS(BB)) bus ();
    tx_arb #(.ID(0), .SUBID(g), .N(N), .SIZE(SZ), .BUFF_BITS(BB), .PKT_FLITS(PF)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );
    assign bus.sw_req   = sw_req[g];
    assign bus.ch_ack   = ch_ack[g];
    assign bus.buf_data = mem[g][bus.buf_sel][bus.buf_addr];
    assign ch_req_w[g]  = bus.ch_req;
    assign flit_w[g]    = bus.ch_flit;
    assign gnt_w[g]     = bus.sw_gnt;
    assign bsel_w[g]    = bus.buf_sel;
    assign addr_w[g]    = bus.buf_addr;
    assign busy_w[g]    = bus.busy;
    assign done_w[g]    = bus.pkt_done;
  end

  function automatic int pfl(input int d);
    return (d == 0) ? 4 : (d == 1) ? 2 : 8;
  endfunction

  function automatic int exp_winner(input int d, input logic [N-1:0] req);
`ifdef TX_ARB_RR_EN
    for (int i = 0; i < N; i++)
      if (req[(ptr_m[d] + i) % N]) return (ptr_m[d] + i) % N;
`else
    for (int i = 0; i < N; i++)
      if (req[i]) return i;
`endif
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_mem(input int d);
    for (int s = 0; s < N; s++)
      for (int a = 0; a < (1 << BB); a++)
        mem[d][s][a] = SZ'($urandom);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int d = 0; d < ND; d++) begin
      sw_req[d] = '0;
      ch_ack[d] = 1'b0;
      ptr_m[d] = 0;
      last_req[d] = 1'b0;
    end
    step();
    step();
    reset = 1'b0;
  endtask

  // One whole packet: grant, flit stream with a randomly slow receiver, done, release.
  task automatic run_packet(input int d, input logic [N-1:0] req, input bit noise,
                            input bit drop_early, input bit spur, output int win);
    int w, got, dones, post, cyc, dly, first;
    bit pend, seen_done;
    logic [N-1:0] gbit;
    logic [SZ-1:0] exp;
    w = exp_winner(d, req);
    gbit = N'(1) << w;
    win = -1;
    sw_req[d] = req;
    step();
    total++;
    if (gnt_w[d] !== gbit || bsel_w[d] !== 2'(w) || busy_w[d] !== 1'b1 || addr_w[d] !== '0) begin
      bad++;
      $display("FAIL grant d=%0d: gnt=%b sel=%0d busy=%b addr=%0d, want gnt=%b sel=%0d busy=1 addr=0",
               d, gnt_w[d], bsel_w[d], busy_w[d], addr_w[d], gbit, w);
    end
    win = int'(bsel_w[d]);
    total++;
    if (ch_req_w[d] !== last_req[d]) begin
      bad++;
      $display("FAIL early_toggle d=%0d: ch_req=%b want %b", d, ch_req_w[d], last_req[d]);
    end
    if (spur) ch_ack[d] = ~ch_ack[d];
    got = 0; dones = 0; post = 0; cyc = 0; dly = 0; first = -1; pend = 0; seen_done = 0;
    while (cyc < 400 && post < 3) begin
      step();
      cyc++;
      if (ch_req_w[d] !== last_req[d]) begin
        last_req[d] = ch_req_w[d];
        if (first < 0) first = cyc;
        exp = mem[d][w][got % (1 << BB)];
        total++;
        if (got >= pfl(d) || flit_w[d] !== exp) begin
          bad++;
          $display("FAIL flit d=%0d idx=%0d: got %h want %h (limit %0d)", d, got, flit_w[d], exp, pfl(d));
        end
        got++;
        pend = 1;
        dly = $urandom_range(0, 2);
      end
      if (done_w[d] === 1'b1) begin
        dones++;
        if (!seen_done) begin
          seen_done = 1;
          sw_req[d] = drop_early ? '0 : gbit;
        end
      end
      if (seen_done) post++;
      else begin
        if (noise) sw_req[d] = (N'($urandom) & ~gbit) | (sw_req[d] & gbit);
        if (drop_early && got >= 1) sw_req[d] = sw_req[d] & ~gbit;
      end
      if (pend) begin
        if (dly == 0) begin
          ch_ack[d] = ~ch_ack[d];
          pend = 0;
        end else dly--;
      end
    end
    total++;
    if (post < 3) begin
      bad++;
      $display("FAIL timeout d=%0d: no pkt_done after %0d cycles, want done", d, cyc);
    end
    total++;
    if (got !== pfl(d)) begin
      bad++;
      $display("FAIL flit_count d=%0d: got %0d want %0d", d, got, pfl(d));
    end
    total++;
    if (dones !== 1) begin
      bad++;
      $display("FAIL done_pulses d=%0d: got %0d want 1", d, dones);
    end
    total++;
    if (first !== 1) begin
      bad++;
      $display("FAIL first_flit_latency d=%0d: got %0d want 1", d, first);
    end
    total++;
    if (gnt_w[d] !== '0 || busy_w[d] !== !drop_early) begin
      bad++;
      $display("FAIL post_packet d=%0d: gnt=%b busy=%b, want gnt=0 busy=%b", d, gnt_w[d], busy_w[d], !drop_early);
    end
    if (!drop_early) begin
      sw_req[d] = '0;
      step();
      total++;
      if (busy_w[d] !== 1'b0) begin
        bad++;
        $display("FAIL release d=%0d: busy=%b want 0", d, busy_w[d]);
      end
    end
    ptr_m[d] = (w + 1) % N;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    for (int d = 0; d < ND; d++) begin
      total++;
      if (ch_req_w[d] !== 1'b0 || flit_w[d] !== '0 || gnt_w[d] !== '0 || bsel_w[d] !== '0 ||
          addr_w[d] !== '0 || busy_w[d] !== 1'b0 || done_w[d] !== 1'b0) begin
        bad++;
        $display("FAIL reset_state d=%0d: req=%b flit=%h gnt=%b sel=%0d addr=%0d busy=%b done=%b, want all 0",
                 d, ch_req_w[d], flit_w[d], gnt_w[d], bsel_w[d], addr_w[d], busy_w[d], done_w[d]);
      end
    end
    do_reset();
  endtask

  task automatic test_basic();
    int w;
    fill_mem(0);
    run_packet(0, 4'b0001, 0, 0, 0, w);
    total++;
    if (w !== 0) begin
      bad++;
      $display("FAIL basic_source: got %0d want 0", w);
    end
  endtask

  task automatic test_arb_order();
    int w;
    int exp_o [4];
`ifdef TX_ARB_RR_EN
    exp_o = '{0, 1, 3, 0};
`else
    exp_o = '{0, 0, 0, 0};
`endif
    do_reset();
    fill_mem(0);
    for (int k = 0; k < 4; k++) begin
      run_packet(0, 4'b1011, 0, 0, 0, w);
      total++;
      if (w !== exp_o[k]) begin
        bad++;
        $display("FAIL arb_order pkt=%0d: got source %0d want %0d", k, w, exp_o[k]);
      end
    end
  endtask

  task automatic test_spurious_ack();
    int w;
    fill_mem(1);
    for (int k = 0; k < 3; k++) begin
      ch_ack[1] = ~ch_ack[1];
      step();
    end
    total++;
    if (busy_w[1] !== 1'b0 || ch_req_w[1] !== last_req[1]) begin
      bad++;
      $display("FAIL idle_ack: busy=%b ch_req=%b, want busy=0 ch_req=%b", busy_w[1], ch_req_w[1], last_req[1]);
    end
    run_packet(1, 4'b0100, 0, 0, 1, w);
  endtask

  task automatic test_reset_mid();
    int got, w;
    fill_mem(2);
    sw_req[2] = 4'b0010;
    got = 0;
    for (int c = 0; c < 50 && got < 2; c++) begin
      step();
      if (ch_req_w[2] !== last_req[2]) begin
        last_req[2] = ch_req_w[2];
        got++;
        if (got < 2) ch_ack[2] = ~ch_ack[2];
      end
    end
    total++;
    if (got !== 2) begin
      bad++;
      $display("FAIL mid_setup: got %0d flits want 2", got);
    end
    reset = 1'b1;
    for (int d = 0; d < ND; d++) sw_req[d] = '0;
    step();
    total++;
    if (ch_req_w[2] !== 1'b0 || gnt_w[2] !== '0 || busy_w[2] !== 1'b0 || addr_w[2] !== '0 || flit_w[2] !== '0) begin
      bad++;
      $display("FAIL mid_reset: req=%b gnt=%b busy=%b addr=%0d flit=%h, want all 0",
               ch_req_w[2], gnt_w[2], busy_w[2], addr_w[2], flit_w[2]);
    end
    reset = 1'b0;
    for (int d = 0; d < ND; d++) begin
      ptr_m[d] = 0;
      last_req[d] = 1'b0;
    end
    run_packet(2, 4'b0010, 0, 0, 0, w);
  endtask

  task automatic test_wrap();
    int w;
    fill_mem(2);
    run_packet(2, 4'b1000, 0, 0, 0, w);
    run_packet(2, 4'b0001, 0, 1, 0, w);
  endtask

  task automatic test_random();
    int d, w;
    logic [N-1:0] r;
    for (int k = 0; k < 12; k++) begin
      d = $urandom_range(0, ND - 1);
      fill_mem(d);
      r = N'($urandom_range(1, (1 << N) - 1));
      run_packet(d, r, 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, w);
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int d = 0; d < ND; d++) begin
      sw_req[d] = '0;
      ch_ack[d] = 1'b0;
      ptr_m[d] = 0;
      last_req[d] = 1'b0;
    end
    test_reset();
    test_basic();
    test_arb_order();
    test_spurious_ack();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
